// File: rtl/mig_init_pkg.sv
// Shared definitions for the MIG bring-up sequencer: state encoding, retry
// low-time and the counter-width helper.
package mig_init_pkg;

    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_WAIT_MIG   = 3'd1;
    localparam logic [2:0] ST_WAIT_CALIB = 3'd2;
    localparam logic [2:0] ST_SETTLE     = 3'd3;
    localparam logic [2:0] ST_STABLE     = 3'd4;
    localparam logic [2:0] ST_RETRY      = 3'd5;
    localparam logic [2:0] ST_FAILED     = 3'd6;

    // Cycles the reset-timer enable is held low before another attempt.
    localparam int RETRY_LOW_CYCLES = 4;

    // Bits needed for a counter running 0 .. max_count-1.
    function automatic int cnt_width(input int max_count);
        return (max_count <= 2) ? 1 : $clog2(max_count);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for slow asynchronous level signals, WIDTH bits wide.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             i_Clock,
    input  logic             i_Reset,
    input  logic [WIDTH-1:0] i_Data,
    output logic [WIDTH-1:0] o_Data
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    // NOTE: clocked state uses non-blocking assignments so both stages sample pre-edge values.
    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= i_Data;
            sync_q <= meta_q;
        end
    end

    assign o_Data = sync_q;

endmodule

// File: rtl/mig_init_sequencer.sv
// DDR bring-up supervisor: PLL lock -> reset timer -> MIG calibration -> settle -> release.
// Optional macro MIG_CALIB_LOSS_RECOVERY_EN: a calibration drop in STABLE triggers a retry.
module mig_init_sequencer
    import mig_init_pkg::*;
#(
    parameter int CALIB_TIMEOUT_CYCLES = 640000,
    parameter int TIMEOUT_WIDTH        = 20,
    parameter int SETTLE_CYCLES        = 1024,
    parameter int MAX_RETRIES          = 3,
    parameter int RETRY_WIDTH          = 2
) (
    input  logic                   i_Clock,
    input  logic                   i_Reset,
    input  logic                   i_Pll_Locked,
    input  logic                   i_Mig_Reset_Released,
    input  logic                   i_Init_Calib_Complete,
    output logic                   o_Timer_Enable,
    output logic                   o_System_Reset,
    output logic                   o_Calib_Done,
    output logic                   o_Failed,
    output logic [RETRY_WIDTH-1:0] o_Retry_Count
);

    // Widen the shared counter if TIMEOUT_WIDTH is too small for either window.
    localparam int CNT_NEED = cnt_width((CALIB_TIMEOUT_CYCLES > SETTLE_CYCLES) ?
                                        CALIB_TIMEOUT_CYCLES : SETTLE_CYCLES);
    localparam int CNT_W    = (TIMEOUT_WIDTH > CNT_NEED) ? TIMEOUT_WIDTH : CNT_NEED;

    localparam logic [CNT_W-1:0]       CNT_MAX        = '1;
    localparam logic [CNT_W-1:0]       TIMEOUT_LAST   = CNT_W'(CALIB_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0]       SETTLE_LAST    = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]       RETRY_LOW_LAST = CNT_W'(RETRY_LOW_CYCLES - 1);
    localparam logic [RETRY_WIDTH-1:0] RETRY_MAX      = RETRY_WIDTH'(MAX_RETRIES);

    logic [1:0]             sync_out;
    logic                   lock_s;
    logic                   calib_s;
    logic [2:0]             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d, cnt_inc;
    logic [RETRY_WIDTH-1:0] retry_q, retry_d;
    logic                   timer_en_q, sys_rst_q, calib_done_q, failed_q;

    sync_2ff #(.WIDTH(2)) u_sync (
        .i_Clock (i_Clock),
        .i_Reset (i_Reset),
        .i_Data  ({i_Init_Calib_Complete, i_Pll_Locked}),
        .o_Data  (sync_out)
    );

    assign lock_s  = sync_out[0];
    assign calib_s = sync_out[1];
    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        retry_d = retry_q;
        if (!lock_s && state_q != ST_FAILED) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:       if (lock_s) state_d = ST_WAIT_MIG;
                ST_WAIT_MIG:   if (i_Mig_Reset_Released) state_d = ST_WAIT_CALIB;
                ST_WAIT_CALIB: begin
                    // A calib rise in the timeout cycle still wins.
                    if (calib_s)                    state_d = ST_SETTLE;
                    else if (cnt_q == TIMEOUT_LAST) state_d = (retry_q < RETRY_MAX) ? ST_RETRY : ST_FAILED;
                    else                            cnt_d   = cnt_inc;
                end
                ST_SETTLE: begin
                    if (!calib_s)                  state_d = ST_WAIT_CALIB;
                    else if (cnt_q == SETTLE_LAST) state_d = ST_STABLE;
                    else                           cnt_d   = cnt_inc;
                end
                ST_STABLE: begin
`ifdef MIG_CALIB_LOSS_RECOVERY_EN
                    if (!calib_s) state_d = (retry_q < RETRY_MAX) ? ST_RETRY : ST_FAILED;
`else
                    state_d = ST_STABLE;
`endif
                end
                ST_RETRY: begin
                    if (cnt_q == RETRY_LOW_LAST) begin
                        state_d = ST_WAIT_MIG;
                        if (retry_q < RETRY_MAX) retry_d = retry_q + 1'b1;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                ST_FAILED: state_d = ST_FAILED;
                default:   state_d = ST_IDLE;
            endcase
        end
    end

    // Outputs are decoded from the next state so they change with the state register.
    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            retry_q      <= '0;
            timer_en_q   <= 1'b0;
            sys_rst_q    <= 1'b1;
            calib_done_q <= 1'b0;
            failed_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            retry_q      <= retry_d;
            timer_en_q   <= (state_d == ST_WAIT_MIG) || (state_d == ST_WAIT_CALIB) ||
                            (state_d == ST_SETTLE)   || (state_d == ST_STABLE);
            sys_rst_q    <= (state_d != ST_STABLE);
            calib_done_q <= (state_d == ST_STABLE);
            failed_q     <= (state_d == ST_FAILED);
        end
    end

    assign o_Timer_Enable = timer_en_q;
    assign o_System_Reset = sys_rst_q;
    assign o_Calib_Done   = calib_done_q;
    assign o_Failed       = failed_q;
    assign o_Retry_Count  = retry_q;

endmodule

// File: tb/tb_mig_init_sequencer.sv
// Directed bench for mig_init_sequencer (timeout 100, settle 8, max retries 2).
module tb_mig_init_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       lock, rel, cal;
    logic       en, srst, done, fail;
    logic [1:0] rc;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       lock;
        logic       rel;
        logic       cal;
        int         ncyc;
        logic       en;
        logic       srst;
        logic       done;
        logic       fail;
        logic [1:0] rc;
    } vec_t;

    vec_t vecs[16];

    always #5 clk = ~clk;

    mig_init_sequencer #(
        .CALIB_TIMEOUT_CYCLES (100),
        .TIMEOUT_WIDTH        (20),
        .SETTLE_CYCLES        (8),
        .MAX_RETRIES          (2),
        .RETRY_WIDTH          (2)
    ) dut (
        .i_Clock               (clk),
        .i_Reset               (rst),
        .i_Pll_Locked          (lock),
        .i_Mig_Reset_Released  (rel),
        .i_Init_Calib_Complete (cal),
        .o_Timer_Enable        (en),
        .o_System_Reset        (srst),
        .o_Calib_Done          (done),
        .o_Failed              (fail),
        .o_Retry_Count         (rc)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic e_en, input logic e_srst,
                              input logic e_done, input logic e_fail, input logic [1:0] e_rc);
        check({tag, ".en"},   32'(en),   32'(e_en));
        check({tag, ".srst"}, 32'(srst), 32'(e_srst));
        check({tag, ".done"}, 32'(done), 32'(e_done));
        check({tag, ".fail"}, 32'(fail), 32'(e_fail));
        check({tag, ".rc"},   32'(rc),   32'(e_rc));
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive(input logic l, input logic r, input logic c);
        lock = l;
        rel  = r;
        cal  = c;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0);
        tick(2);
        rst = 1'b0;
        tick(1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        // lock rel cal ncyc | en srst done fail rc
        vecs[0]  = '{1'b0, 1'b0, 1'b0,  3, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0};
        vecs[1]  = '{1'b1, 1'b0, 1'b0,  2, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0};
        vecs[2]  = '{1'b1, 1'b0, 1'b0,  1, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0};
        vecs[3]  = '{1'b1, 1'b0, 1'b0,  5, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0};
        vecs[4]  = '{1'b1, 1'b1, 1'b0,  1, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0};
        vecs[5]  = '{1'b1, 1'b1, 1'b1,  2, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0};
        vecs[6]  = '{1'b1, 1'b1, 1'b1,  1, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0};
        vecs[7]  = '{1'b1, 1'b1, 1'b1,  7, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0};
        vecs[8]  = '{1'b1, 1'b1, 1'b1,  1, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0};
        vecs[9]  = '{1'b1, 1'b1, 1'b1, 20, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0};
        vecs[10] = '{1'b0, 1'b1, 1'b1,  2, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0};
        vecs[11] = '{1'b0, 1'b1, 1'b1,  1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0};
        vecs[12] = '{1'b1, 1'b0, 1'b1,  3, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0};
        vecs[13] = '{1'b1, 1'b1, 1'b1,  1, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0};
        vecs[14] = '{1'b1, 1'b1, 1'b1,  8, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0};
        vecs[15] = '{1'b1, 1'b1, 1'b1,  1, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0};

        // Asynchronous reset values before any clock edge.
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0);
        #2;
        check_outs("reset_async", 1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
        tick(2);
        rst = 1'b0;

        // Nominal bring-up, lock loss from STABLE, relock with calib already high.
        for (int i = 0; i < 16; i++) begin
            drive(vecs[i].lock, vecs[i].rel, vecs[i].cal);
            tick(vecs[i].ncyc);
            check_outs($sformatf("vec%0d", i), vecs[i].en, vecs[i].srst, vecs[i].done,
                       vecs[i].fail, vecs[i].rc);
        end

        // Timeout retry, lock loss in WAIT_CALIB, relock, then calib drop in STABLE.
        do_reset();
        drive(1'b1, 1'b0, 1'b0);
        tick(3);
        check_outs("to_lock", 1'b1, 1'b1, 1'b0, 1'b0, 2'd0);
        drive(1'b1, 1'b1, 1'b0);
        tick(100);
        check_outs("to_last_wait", 1'b1, 1'b1, 1'b0, 1'b0, 2'd0);
        tick(1);
        check_outs("to_retry_enter", 1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
        drive(1'b1, 1'b0, 1'b0);
        tick(3);
        check_outs("to_retry_low4", 1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
        tick(1);
        check_outs("to_retry_exit", 1'b1, 1'b1, 1'b0, 1'b0, 2'd1);
        tick(5);
        drive(1'b1, 1'b1, 1'b0);
        tick(20);
        drive(1'b0, 1'b1, 1'b0);
        tick(2);
        check_outs("ll_latency", 1'b1, 1'b1, 1'b0, 1'b0, 2'd1);
        tick(1);
        check_outs("ll_idle", 1'b0, 1'b1, 1'b0, 1'b0, 2'd1);
        drive(1'b0, 1'b0, 1'b0);
        tick(5);
        drive(1'b1, 1'b0, 1'b0);
        tick(3);
        check_outs("relock", 1'b1, 1'b1, 1'b0, 1'b0, 2'd1);
        drive(1'b1, 1'b1, 1'b0);
        tick(1);
        drive(1'b1, 1'b1, 1'b1);
        tick(10);
        check_outs("relock_settle", 1'b1, 1'b1, 1'b0, 1'b0, 2'd1);
        tick(1);
        check_outs("relock_stable", 1'b1, 1'b0, 1'b1, 1'b0, 2'd1);
        drive(1'b1, 1'b1, 1'b0);
        tick(2);
        check_outs("drop_latency", 1'b1, 1'b0, 1'b1, 1'b0, 2'd1);
        tick(1);
`ifdef MIG_CALIB_LOSS_RECOVERY_EN
        check_outs("drop_retry", 1'b0, 1'b1, 1'b0, 1'b0, 2'd1);
        tick(3);
        check_outs("drop_retry_low", 1'b0, 1'b1, 1'b0, 1'b0, 2'd1);
        tick(1);
        check_outs("drop_retry_exit", 1'b1, 1'b1, 1'b0, 1'b0, 2'd2);
`else
        check_outs("drop_ignored", 1'b1, 1'b0, 1'b1, 1'b0, 2'd1);
        tick(20);
        check_outs("drop_ignored_hold", 1'b1, 1'b0, 1'b1, 1'b0, 2'd1);
`endif

        // Retry exhaustion, sticky FAILED, cleared only by reset.
        do_reset();
        drive(1'b1, 1'b0, 1'b0);
        tick(3);
        for (int r = 0; r < 2; r++) begin
            drive(1'b1, 1'b1, 1'b0);
            tick(100);
            check_outs($sformatf("ex%0d_wait", r), 1'b1, 1'b1, 1'b0, 1'b0, 2'(r));
            tick(1);
            check_outs($sformatf("ex%0d_retry", r), 1'b0, 1'b1, 1'b0, 1'b0, 2'(r));
            drive(1'b1, 1'b0, 1'b0);
            tick(4);
            check_outs($sformatf("ex%0d_back", r), 1'b1, 1'b1, 1'b0, 1'b0, 2'(r + 1));
        end
        drive(1'b1, 1'b1, 1'b0);
        tick(100);
        check_outs("ex_last_wait", 1'b1, 1'b1, 1'b0, 1'b0, 2'd2);
        tick(1);
        check_outs("ex_failed", 1'b0, 1'b1, 1'b0, 1'b1, 2'd2);
        drive(1'b1, 1'b1, 1'b1);
        tick(1000);
        check_outs("ex_sticky", 1'b0, 1'b1, 1'b0, 1'b1, 2'd2);
        drive(1'b0, 1'b0, 1'b0);
        tick(10);
        check_outs("ex_sticky_nolock", 1'b0, 1'b1, 1'b0, 1'b1, 2'd2);
        rst = 1'b1;
        #2;
        check_outs("ex_reset", 1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
        tick(2);
        rst = 1'b0;

        // Settle glitch: 5 high, 1 low, then high; release 6 cycles later than nominal.
        do_reset();
        drive(1'b1, 1'b0, 1'b0);
        tick(3);
        drive(1'b1, 1'b1, 1'b0);
        tick(11);
        drive(1'b1, 1'b1, 1'b1);
        tick(5);
        drive(1'b1, 1'b1, 1'b0);
        tick(1);
        drive(1'b1, 1'b1, 1'b1);
        tick(4);
        check_outs("gl_nominal_point", 1'b1, 1'b1, 1'b0, 1'b0, 2'd0);
        tick(6);
        check_outs("gl_before", 1'b1, 1'b1, 1'b0, 1'b0, 2'd0);
        tick(1);
        check_outs("gl_release", 1'b1, 1'b0, 1'b1, 1'b0, 2'd0);

        // Reset mid-operation reasserts system reset without a clock edge.
        rst = 1'b1;
        #2;
        check_outs("async_from_stable", 1'b0, 1'b1, 1'b0, 1'b0, 2'd0);
        tick(2);
        rst = 1'b0;
        tick(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mig_init_sequencer.md
# mig_init_sequencer

Supervises DDR bring-up downstream of the MIG reset hold timer. Enables the timer once the PLL is locked, waits for the timer to release the MIG, and then waits for MIG calibration. On calibration timeout it retries by dropping the timer enable. It holds the user-logic system reset until calibration has been stable for a settle window, so everything past the memory controller sees one clean ready edge.

## Interface
- CALIB_TIMEOUT_CYCLES, 640000, cycles allowed in WAIT_CALIB before a retry (2 ms at 320 MHz)
- TIMEOUT_WIDTH, 20, width of the shared timeout/settle counter
- SETTLE_CYCLES, 1024, consecutive cycles calibration must stay high before release
- MAX_RETRIES, 3, retries allowed before FAILED
- RETRY_WIDTH, 2, width of o_Retry_Count
- i_Clock  in  1  system clock, same domain as the reset timer
- i_Reset  in  1  asynchronous, active-high reset
- i_Pll_Locked  in  1  PLL lock, asynchronous, synchronized internally
- i_Mig_Reset_Released  in  1  reset timer output; high = hold time elapsed
- i_Init_Calib_Complete  in  1  MIG calibration done, asynchronous, synchronized internally
- o_Timer_Enable  out  1  drives the reset timer enable
- o_System_Reset  out  1  active-high reset to user logic
- o_Calib_Done  out  1  memory ready
- o_Failed  out  1  sticky failure flag
- o_Retry_Count  out  RETRY_WIDTH  retries consumed

## Operation
- FSM states: IDLE, WAIT_MIG, WAIT_CALIB, SETTLE, STABLE, RETRY, FAILED. All outputs are registered Moore decodes of the state.
- IDLE: when synced lock = 1, go to WAIT_MIG.
- WAIT_MIG: o_Timer_Enable = 1. When i_Mig_Reset_Released = 1, go to WAIT_CALIB and clear the counter.
- WAIT_CALIB: o_Timer_Enable = 1 and the counter increments.
  - Synced calib = 1: go to SETTLE and clear the counter.
  - Counter = CALIB_TIMEOUT_CYCLES-1 with no calib: go to RETRY if o_Retry_Count < MAX_RETRIES, else go to FAILED.
- RETRY: o_Timer_Enable = 0 for RETRY_LOW_CYCLES (4). Then increment o_Retry_Count and go to WAIT_MIG.
- SETTLE: the counter increments while synced calib = 1.
  - Calib drops: go back to WAIT_CALIB with the counter cleared. No retry is consumed.
  - Counter = SETTLE_CYCLES-1: go to STABLE.
- STABLE: o_System_Reset = 0 and o_Calib_Done = 1.
- FAILED: o_Timer_Enable = 0, o_System_Reset = 1, o_Failed = 1. Sticky until i_Reset.
- o_System_Reset = 1 and o_Calib_Done = 0 in every state except STABLE.
- Priority, highest first:
  - i_Reset.
  - Synced lock = 0 in any state except FAILED: go to IDLE. o_Retry_Count is preserved.
  - Calib rising in the timeout cycle: calib wins, so the state goes to SETTLE.
- The counter saturates and never wraps. o_Retry_Count never exceeds MAX_RETRIES.

## Timing
- Reset values: state IDLE, o_Timer_Enable 0, o_System_Reset 1, o_Calib_Done 0, o_Failed 0, o_Retry_Count 0, counter 0, sync flops 0.
- The async inputs pass through 2 flops, so there are 2 cycles of input latency plus 1 cycle for the state register. Example: a lock rise in cycle n gives o_Timer_Enable high in cycle n+3.
- From synced calib high (continuous) to o_System_Reset low: SETTLE_CYCLES+1 cycles.
- Reset asserted mid-operation: all outputs return to their reset values asynchronously. o_System_Reset rises with no clock edge.
- i_Mig_Reset_Released is same-domain and is not synchronized.

## Configuration
- MIG_CALIB_LOSS_RECOVERY_EN defined:
  - A synced calib drop in STABLE reasserts o_System_Reset and clears o_Calib_Done on the next cycle.
  - The FSM then enters RETRY, consuming a retry. If the budget is exhausted, it enters FAILED instead.
- Not defined: STABLE is terminal, and later calib drops are ignored until i_Reset or a loss of lock.

## Structure
- Package mig_init_pkg holds:
  - the state encoding localparams (3-bit)
  - RETRY_LOW_CYCLES = 4
  - the shared counter-width helper
- Sub-module sync_2ff (parameterized width) synchronizes i_Pll_Locked and i_Init_Calib_Complete. There is one instance of width 2.

## Test plan
Bench parameters: CALIB_TIMEOUT_CYCLES=100, SETTLE_CYCLES=8, MAX_RETRIES=2.
- Nominal: lock at cycle 10 -> o_Timer_Enable at 13. Release at 50 and calib at 60 -> o_System_Reset falls at 60+2+9, o_Calib_Done 1, retries 0.
- Timeout retry: no calib -> enable low for exactly 4 cycles at 100 cycles after release, retry count 1. Calib on the second attempt -> STABLE.
- Exhaustion: calib never asserts -> 2 retries, then o_Failed=1 and enable 0. Holds for 1000 cycles, clears only on i_Reset.
- Settle glitch: calib high for 5 cycles, low for 1, then high -> the settle restarts, the release is delayed by 6 cycles, and the retry count is unchanged.
- Lock loss in WAIT_CALIB: enable drops 3 cycles later, state IDLE, retry count kept. Relock -> normal sequence.
- Calib drop in STABLE: with MIG_CALIB_LOSS_RECOVERY_EN, o_System_Reset=1 after sync latency and the retry count increments. Without it, the outputs are unchanged.
